// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a runtime baud divider.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          baud_div,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [15:0]            cnt, cnt_next;
    logic [15:0]            div_q, div_next;
    logic [IDX_W-1:0]       idx, idx_next;
    logic [DATA_BITS-1:0]   shift, shift_next;
    logic [DATA_BITS-1:0]   data_next;
    logic                   valid_next;
    logic                   ferr_next;
    logic [15:0]            half_m1;
    logic [15:0]            full_m1;

    assign rxs     = sync_q[SYNC_STAGES-1];
    assign half_m1 = (div_q >> 1) - 16'd1;
    assign full_m1 = div_q - 16'd1;
    assign rx_busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_next;
    logic perr_q, perr_next;
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '1;
            state     <= IDLE;
            cnt       <= '0;
            div_q     <= '0;
            idx       <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], RX};
            state     <= state_next;
            cnt       <= cnt_next;
            div_q     <= div_next;
            idx       <= idx_next;
            shift     <= shift_next;
            rx_data   <= data_next;
            rx_valid  <= valid_next;
            frame_err <= ferr_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            par_bad <= par_bad_next;
            perr_q  <= perr_next;
        end
    end
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 16'd1;
        div_next   = div_q;
        idx_next   = idx;
        shift_next = shift;
        data_next  = rx_data;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad;
        perr_next    = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rxs) begin
                    state_next = START;
                    div_next   = baud_div;
                end
            end
            START: begin
                if (cnt == half_m1) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == full_m1) begin
                    cnt_next   = '0;
                    shift_next = {rxs, shift[DATA_BITS-1:1]};
                    idx_next   = idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == full_m1) begin
                    cnt_next     = '0;
                    par_bad_next = rxs ^ (^shift);
                    state_next   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == full_m1) begin
                    cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                    perr_next = par_bad;
`endif
                    if (rxs) begin
                        data_next  = shift;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            // Held-low line must return high before a new start bit is accepted.
            BREAK: begin
                cnt_next = '0;
                if (rxs) state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx; frame layout follows UART_RX_PARITY_EN.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic        RX;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_busy;
    logic        frame_err;
    logic        parity_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int nv = 0, nf = 0, np = 0, npv = 0, nbad = 0;
    int vt[32];
    logic [7:0] vd[32];

    uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_div  (baud_div),
        .RX        (RX),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            if (nv < 32) begin
                vt[nv] = cyc;
                vd[nv] = rx_data;
            end
            nv++;
        end
        if (frame_err) nf++;
        if (parity_err) np++;
        if (parity_err && rx_valid) npv++;
        if (frame_err && rx_valid) nbad++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic bit_time(input int div);
        repeat (div) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
        int div;
        div = int'(baud_div);
        @(negedge clk);
        RX = 1'b0;
        start_cyc = cyc;
        repeat (div - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            bit_time(div);
        end
`ifdef UART_RX_PARITY_EN
        RX = (^d) ^ bad_par;
        bit_time(div);
`else
        if (bad_par) RX = 1'b1;
`endif
        RX = stop_bit;
        bit_time(div);
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int v0, f0, p0, pv0, exp_lat, diff, s0;
        logic [7:0] prev;

        RX = 1'b1;
        rst = 1'b1;
        baud_div = 16'd233;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_busy", 32'(rx_busy), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_perr", 32'(parity_err), 32'h0);
        rst = 1'b0;
        idle(20);

        // Single 0x55 frame with latency check
        v0 = nv; f0 = nf;
        send_frame(8'h55, 1'b1, 1'b0);
        check("t1_busy_end_stop", 32'(rx_busy), 32'h0);
        check("t1_valid_cnt", 32'(nv - v0), 32'd1);
        check("t1_data", 32'(vd[v0]), 32'h55);
        check("t1_ferr", 32'(nf - f0), 32'd0);
        exp_lat = (NBITS - 1) * 233 + 116 + 2 + 1;
        diff = vt[v0] - start_cyc;
        check("t1_latency_in_window", 32'(diff >= exp_lat - 1 && diff <= exp_lat + 1), 32'd1);
        idle(100);

        // Back-to-back 0xAA, 0x7F with zero idle gap
        v0 = nv;
        send_frame(8'hAA, 1'b1, 1'b0);
        send_frame(8'h7F, 1'b1, 1'b0);
        idle(20);
        check("t2_valid_cnt", 32'(nv - v0), 32'd2);
        check("t2_data0", 32'(vd[v0]), 32'hAA);
        check("t2_data1", 32'(vd[v0 + 1]), 32'h7F);
        diff = vt[v0 + 1] - vt[v0];
        check("t2_spacing_in_window", 32'(diff >= NBITS * 233 - 2 && diff <= NBITS * 233 + 2), 32'd1);

        // 50-cycle glitch is a false start
        v0 = nv; f0 = nf;
        @(negedge clk);
        RX = 1'b0;
        repeat (50) @(negedge clk);
        idle(120);
        check("t3_busy", 32'(rx_busy), 32'h0);
        check("t3_valid_cnt", 32'(nv - v0), 32'd0);
        check("t3_ferr", 32'(nf - f0), 32'd0);
        idle(200);

        // Stop bit low followed by a held break
        v0 = nv; f0 = nf;
        prev = rx_data;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (3 * 233) @(negedge clk);
        check("t4_busy_in_break", 32'(rx_busy), 32'h1);
        check("t4_ferr_cnt", 32'(nf - f0), 32'd1);
        check("t4_valid_cnt", 32'(nv - v0), 32'd0);
        check("t4_data_hold", 32'(rx_data), 32'h7F);
        check("t4_data_prev", 32'(rx_data), 32'(prev));
        idle(10);
        check("t4_busy_release", 32'(rx_busy), 32'h0);
        idle(100);
        v0 = nv;
        send_frame(8'h81, 1'b1, 1'b0);
        idle(20);
        check("t4_next_valid", 32'(nv - v0), 32'd1);
        check("t4_next_data", 32'(vd[v0]), 32'h81);

        // Reset mid-frame at data bit 4
        v0 = nv; f0 = nf; p0 = np;
        fork
            send_frame(8'hF0, 1'b1, 1'b0);
            begin
                repeat (233 * 5 + 116) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        idle(300);
        check("t5_abort_valid", 32'(nv - v0), 32'd0);
        check("t5_abort_ferr", 32'(nf - f0), 32'd0);
        check("t5_abort_perr", 32'(np - p0), 32'd0);
        check("t5_abort_data_reset", 32'(rx_data), 32'h00);
        check("t5_abort_busy", 32'(rx_busy), 32'h0);
        v0 = nv;
        send_frame(8'h12, 1'b1, 1'b0);
        idle(20);
        check("t5_next_valid", 32'(nv - v0), 32'd1);
        check("t5_next_data", 32'(vd[v0]), 32'h12);

        // Minimum divider
        baud_div = 16'd4;
        v0 = nv; f0 = nf;
        idle(10);
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(10);
        check("t5_div4_valid", 32'(nv - v0), 32'd1);
        check("t5_div4_data", 32'(vd[v0]), 32'hC3);
        check("t5_div4_ferr", 32'(nf - f0), 32'd0);
        baud_div = 16'd233;
        idle(20);

`ifdef UART_RX_PARITY_EN
        // Even parity good then bad
        v0 = nv; p0 = np; pv0 = npv;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(20);
        check("t6_good_valid", 32'(nv - v0), 32'd1);
        check("t6_good_perr", 32'(np - p0), 32'd0);
        check("t6_good_data", 32'(vd[v0]), 32'h07);
        v0 = nv; p0 = np; pv0 = npv;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(20);
        check("t6_bad_valid", 32'(nv - v0), 32'd1);
        check("t6_bad_perr", 32'(np - p0), 32'd1);
        check("t6_bad_coincident", 32'(npv - pv0), 32'd1);
        check("t6_bad_data", 32'(vd[v0]), 32'h07);
`else
        check("no_parity_pulses", 32'(np), 32'd0);
`endif

        s0 = nbad;
        check("valid_with_ferr", 32'(s0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
